mips_bus_initiator: RTL and testbench
=====================================

# mips_bus_initiator

Synthesizable initiator end of the CPU memory bus (address/read/write/waitrequest/writedata/byteenable/readdata). It sits between the CPU load/store datapath and external memory and turns one load or store request into one bus transaction. It generates byte enables and lane-shifted write data, holds strobes through `waitrequest`, and returns aligned, sign- or zero-extended load data. Requests that are not naturally aligned are rejected without starting a bus cycle.

## Interface
- `TIMEOUT_CYCLES`, 256: waitrequest watchdog limit. Only used when the watchdog is compiled in.
- `clk` in 1: single clock; everything samples on the rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `req_valid` in 1: request present.
- `req_ready` out 1: request can be accepted.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is illegal and raises an error.
- `req_signed` in 1: sign-extend load data.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_err` out 1: qualifies `rsp_valid`; signals misalignment, illegal size or timeout.
- `rsp_rdata` out 32: aligned load result; 0 for stores and errors.
- `address` out 32: word-aligned bus address (`req_addr[31:2]`, 2'b00).
- `read`, `write` out 1 each: bus strobes, never both high.
- `waitrequest` in 1: memory stall.
- `writedata` out 32: lane-positioned store data.
- `byteenable` out 4: active lanes; bit k = bits [8k+7:8k].
- `readdata` in 32: valid the cycle after a read is accepted.

## Operation
- States: IDLE, BUS, RDATA, RESP.
- IDLE
  - `req_ready`=1. A request is accepted when `req_valid`=1 at the edge.
  - An illegal request (size 3, half with `addr[0]`=1, word with `addr[1:0]`≠0) goes to RESP with `rsp_err`=1 and no bus cycle.
  - Otherwise the request is latched and the FSM goes to BUS.
- BUS
  - Drives `address`, `byteenable` and `writedata`, plus `read` or `write`, all constant while `waitrequest`=1.
  - A transaction completes at the first edge with `waitrequest`=0. A write then goes to RESP; a read goes to RDATA.
- RDATA
  - Captures `readdata`.
  - Extracts the lane selected by `addr[1:0]`, extends it per `req_signed`, and goes to RESP.
- RESP
  - `rsp_valid`=1 for exactly one cycle, then back to IDLE.
  - `req_ready`=0 in every state except IDLE. There is no pipelining; one request is outstanding at most.
- Lane rules (little-endian lanes)
  - Byte at offset k: `byteenable` = 1<<k, `writedata` = {4{wdata[7:0]}}.
  - Half at offset 0/2: `byteenable` = 4'b0011/4'b1100, `writedata` = {2{wdata[15:0]}}.
  - Word: `byteenable` = 4'b1111, `writedata` = wdata.
  - `byteenable` is 4'b0000 whenever neither strobe is high.
- Load extension
  - Byte: sign from bit 7 of the lane when `req_signed`=1, else zero-fill.
  - Half: same rule, sign from bit 15 of the lane.
  - Word: passed through unchanged.

## Timing
- Reset values: FSM = IDLE, `req_ready`=1 (first cycle after reset released). All other outputs are 0: `read`, `write`, `address`, `writedata`, `byteenable`, `rsp_valid`, `rsp_err`, `rsp_rdata`.
- Reset in mid-transaction drops the strobes at that edge. No response is produced for the aborted request.
- Latency with `waitrequest`=0, counting the acceptance edge as cycle 0:
  - Strobe high in cycle 1.
  - Store: `rsp_valid` in cycle 2.
  - Load: `readdata` sampled in cycle 2, `rsp_valid` in cycle 3.
- Each cycle of `waitrequest`=1 adds one cycle.
- Illegal request: `rsp_valid`/`rsp_err` in cycle 1.
- `waitrequest` is ignored when no strobe is high.
- `readdata` is ignored outside RDATA.

## Configuration
- `MIPS_BUS_INITIATOR_TIMEOUT_EN` defined
  - A counter runs in BUS while `waitrequest`=1 and clears on state entry.
  - When it reaches `TIMEOUT_CYCLES`, the strobes drop and the FSM goes to RESP with `rsp_err`=1.
- Undefined: no counter; BUS waits indefinitely and `TIMEOUT_CYCLES` is unused.

## Structure
- Package `mips_bus_pkg` holds:
  - the size encoding constants (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`);
  - the FSM state enum;
  - the byteenable-generation function;
  - the alignment-check function.
- Sub-module `mips_load_align`: combinational lane select plus sign/zero extension from `readdata`, `addr[1:0]`, size and signed. It is instantiated once.

## Test plan
- Word load at 0xBFC00018, memory holds 0x00000019, `waitrequest`=0 -> `read` in cycle 1, `address`=0xBFC00018, `byteenable`=4'b1111, `rsp_rdata`=0x00000019 with `rsp_valid` in cycle 3.
- Signed byte load at offset 3 of 0x80FF7F01 -> `rsp_rdata`=0xFFFFFF80. Unsigned -> 0x00000080.
- Half store of 0xBEEF at offset 2 with `waitrequest` held high 3 cycles -> `byteenable`=4'b1100 and `writedata`=0xBEEFBEEF held stable; `rsp_valid` in cycle 5.
- Word load at 0xBFC00002 -> `rsp_err`=1 in cycle 1, `read` and `write` never asserted.
- Reset=0 in cycle 2 of a stalled read -> `read`=0 and `req_ready`=1 after release, no `rsp_valid`.
- With `MIPS_BUS_INITIATOR_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, `waitrequest` stuck at 1 -> strobe drops, `rsp_err`=1 pulse.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: size encodings, FSM state type and lane helpers shared by
// the MIPS bus initiator and its load-alignment sub-module.
package mips_bus_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RDATA = 2'd2,
        RESP  = 2'd3
    } bus_state_e;

    // Little-endian lane mask for an access of the given size at a byte offset.
    function automatic logic [3:0] gen_byteenable(input logic [1:0] size,
                                                  input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << offset;
            SIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // True when the access is naturally aligned and the size code is legal.
    function automatic logic is_aligned(input logic [1:0] size,
                                        input logic [1:0] offset);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~offset[0];
            SIZE_WORD: ok = (offset == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_load_align.sv
// mips_load_align: picks the addressed lane out of a bus read word and
// sign- or zero-extends it to 32 bits.
module mips_load_align
    import mips_bus_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension according to access size.
    always_comb begin
        case (offset)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        half_s = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: data = {{24{is_signed & byte_s[7]}}, byte_s};
            SIZE_HALF: data = {{16{is_signed & half_s[15]}}, half_s};
            SIZE_WORD: data = rdata;
            default:   data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mips_bus_initiator.sv
// mips_bus_initiator: turns one CPU load/store request into one bus
// transaction with byte enables, lane-replicated write data and aligned
// load return. Optional waitrequest watchdog: MIPS_BUS_INITIATOR_TIMEOUT_EN.
module mips_bus_initiator
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    bus_state_e  state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  offset_q, offset_d;
    logic        signed_q, signed_d;
    logic [31:0] load_data_s;
    logic [31:0] lane_wdata_s;

`ifdef MIPS_BUS_INITIATOR_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = TIMEOUT_CYCLES;
`endif

    mips_load_align u_load_align (
        .rdata     (readdata),
        .offset    (offset_q),
        .size      (size_q),
        .is_signed (signed_q),
        .data      (load_data_s)
    );

    // Replicate right-justified store data across every lane of its size.
    always_comb begin
        case (req_size)
            SIZE_BYTE: lane_wdata_s = {4{req_wdata[7:0]}};
            SIZE_HALF: lane_wdata_s = {2{req_wdata[15:0]}};
            SIZE_WORD: lane_wdata_s = req_wdata;
            default:   lane_wdata_s = 32'd0;
        endcase
    end

    // Next-state and next-output logic for the request/bus/response FSM.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_rdata_d  = rsp_rdata_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        size_d       = size_q;
        offset_d     = offset_q;
        signed_d     = signed_q;
`ifdef MIPS_BUS_INITIATOR_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    if (!is_aligned(req_size, req_addr[1:0])) begin
                        // Rejected without touching the bus.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d      = BUS;
                        address_d    = {req_addr[31:2], 2'b00};
                        writedata_d  = lane_wdata_s;
                        byteenable_d = gen_byteenable(req_size, req_addr[1:0]);
                        read_d       = ~req_write;
                        write_d      = req_write;
                        size_d       = req_size;
                        offset_d     = req_addr[1:0];
                        signed_d     = req_signed;
`ifdef MIPS_BUS_INITIATOR_TIMEOUT_EN
                        tmo_cnt_d    = 32'd0;
`endif
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    byteenable_d = 4'b0000;
                    if (write_q) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d = RDATA;
                    end
                end else begin
`ifdef MIPS_BUS_INITIATOR_TIMEOUT_EN
                    if (tmo_cnt_q >= TIMEOUT_CYCLES - 32'd1) begin
                        read_d       = 1'b0;
                        write_d      = 1'b0;
                        byteenable_d = 4'b0000;
                        state_d      = RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_err_d    = 1'b1;
                        rsp_rdata_d  = 32'd0;
                        tmo_cnt_d    = 32'd0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 32'd1;
                    end
`else
                    state_d = BUS;
`endif
                end
            end
            RDATA: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = load_data_s;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'd0;
            end
            default: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                rsp_valid_d  = 1'b0;
                rsp_err_d    = 1'b0;
                rsp_rdata_d  = 32'd0;
                read_d       = 1'b0;
                write_d      = 1'b0;
                byteenable_d = 4'b0000;
            end
        endcase
    end

    // State and registered outputs; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            address_q    <= 32'd0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= 32'd0;
            byteenable_q <= 4'b0000;
            size_q       <= 2'd0;
            offset_q     <= 2'd0;
            signed_q     <= 1'b0;
`ifdef MIPS_BUS_INITIATOR_TIMEOUT_EN
            tmo_cnt_q    <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            size_q       <= size_d;
            offset_q     <= offset_d;
            signed_q     <= signed_d;
`ifdef MIPS_BUS_INITIATOR_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_bus_initiator.sv
// tb_mips_bus_initiator: scoreboard bench for the MIPS bus initiator with a
// simple memory model that stalls a programmable number of strobe cycles.
module tb_mips_bus_initiator;
    import mips_bus_pkg::*;

    localparam int unsigned TMO = 32'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest = 1'b0;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata = 32'd0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          stall_cfg = 0;
    int          strobe_run = 0;
    int          strobe_seen = 0;
    logic [31:0] mem_word = 32'd0;
    logic        rd_accept = 1'b0;

    mips_bus_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .address     (address),
        .read        (read),
        .write       (write),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: stall the first stall_cfg strobe cycles, then accept.
    always @(negedge clk) begin
        if (read || write) begin
            waitrequest = (strobe_run < stall_cfg);
            strobe_run  = strobe_run + 1;
            strobe_seen = strobe_seen + 1;
        end else begin
            waitrequest = (stall_cfg > 0);
            strobe_run  = 0;
        end
        rd_accept = read && !waitrequest;
    end

    // Read data is only meaningful the cycle after a read is accepted.
    always @(posedge clk) begin
        #1;
        readdata = rd_accept ? mem_word : 32'hDEADBEEF;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic rsp_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
            if (read && write) check("both_strobes", 32'd1, 32'd0);
        end
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc_cyc   = cyc - 1;
    endtask

    task automatic expect_rsp(input logic err, input logic [31:0] rd, input int lat);
        exp_t e;
        e.err   = err;
        e.rdata = rd;
        e.lat   = lat;
        e.acc   = acc_cyc;
        exp_q.push_back(e);
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 64; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("rsp_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic run_load(input logic [31:0] addr, input logic [1:0] sz, input logic sgn,
                            input logic [31:0] mem, input int stall,
                            input logic [31:0] exp_d, input logic [3:0] exp_be);
        stall_cfg = stall;
        mem_word  = mem;
        drive_req(1'b0, sz, sgn, addr, 32'd0);
        expect_rsp(1'b0, exp_d, 3 + stall);
        @(negedge clk);
        check("ld_read", 32'(read), 32'd1);
        check("ld_write", 32'(write), 32'd0);
        check("ld_addr", address, {addr[31:2], 2'b00});
        check("ld_be", 32'(byteenable), 32'(exp_be));
        wait_rsp();
        check("ld_idle_read", 32'(read), 32'd0);
        check("ld_idle_be", 32'(byteenable), 32'd0);
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [1:0] sz,
                             input logic [31:0] wd, input int stall,
                             input logic [31:0] exp_wd, input logic [3:0] exp_be);
        stall_cfg = stall;
        drive_req(1'b1, sz, 1'b0, addr, wd);
        expect_rsp(1'b0, 32'd0, 2 + stall);
        for (int c = 0; c <= stall; c++) begin
            @(negedge clk);
            check("st_write", 32'(write), 32'd1);
            check("st_read", 32'(read), 32'd0);
            check("st_addr", address, {addr[31:2], 2'b00});
            check("st_be", 32'(byteenable), 32'(exp_be));
            check("st_wdata", writedata, exp_wd);
        end
        wait_rsp();
        check("st_idle_write", 32'(write), 32'd0);
        stall_cfg = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        fork
            rsp_monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_read", 32'(read), 32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_address", address, 32'd0);
        check("rst_writedata", writedata, 32'd0);
        check("rst_byteenable", 32'(byteenable), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);

        // Loads: word, signed/unsigned byte and half, stalled word
        run_load(32'hBFC00018, SIZE_WORD, 1'b0, 32'h00000019, 0, 32'h00000019, 4'b1111);
        run_load(32'h00001003, SIZE_BYTE, 1'b1, 32'h80FF7F01, 0, 32'hFFFFFF80, 4'b1000);
        run_load(32'h00001003, SIZE_BYTE, 1'b0, 32'h80FF7F01, 0, 32'h00000080, 4'b1000);
        run_load(32'h00001000, SIZE_BYTE, 1'b1, 32'h80FF7F01, 0, 32'h00000001, 4'b0001);
        run_load(32'h00001002, SIZE_HALF, 1'b1, 32'h80FF7F01, 0, 32'hFFFF80FF, 4'b1100);
        run_load(32'h00001000, SIZE_HALF, 1'b0, 32'h80FF7F01, 0, 32'h00007F01, 4'b0011);
        run_load(32'h00002000, SIZE_HALF, 1'b1, 32'h12348001, 0, 32'hFFFF8001, 4'b0011);
        run_load(32'h00003004, SIZE_WORD, 1'b1, 32'h01234567, 2, 32'h01234567, 4'b1111);

        // Stores: half with 3 stall cycles, byte, stalled word
        run_store(32'h20000002, SIZE_HALF, 32'h1234BEEF, 3, 32'hBEEFBEEF, 4'b1100);
        run_store(32'h20000101, SIZE_BYTE, 32'hFFFFFFA5, 0, 32'hA5A5A5A5, 4'b0010);
        run_store(32'h20000010, SIZE_WORD, 32'hCAFEF00D, 1, 32'hCAFEF00D, 4'b1111);

        // Illegal requests never touch the bus
        s0 = strobe_seen;
        drive_req(1'b0, SIZE_WORD, 1'b0, 32'hBFC00002, 32'd0);
        expect_rsp(1'b1, 32'd0, 1);
        wait_rsp();
        drive_req(1'b1, SIZE_HALF, 1'b0, 32'h00000101, 32'h0000FFFF);
        expect_rsp(1'b1, 32'd0, 1);
        wait_rsp();
        drive_req(1'b0, 2'd3, 1'b0, 32'h00000000, 32'd0);
        expect_rsp(1'b1, 32'd0, 1);
        wait_rsp();
        check("illegal_no_strobe", 32'(strobe_seen - s0), 32'd0);

        // Reset in cycle 2 of a stalled read: no response afterwards
        stall_cfg = 1000;
        drive_req(1'b0, SIZE_WORD, 1'b0, 32'h00000040, 32'd0);
        @(negedge clk);
        check("abort_read_before", 32'(read), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_read", 32'(read), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        stall_cfg = 0;
        repeat (6) @(negedge clk);
        run_load(32'h00000044, SIZE_WORD, 1'b0, 32'h55AA55AA, 0, 32'h55AA55AA, 4'b1111);

`ifdef MIPS_BUS_INITIATOR_TIMEOUT_EN
        // Watchdog: waitrequest stuck high
        stall_cfg = 1000;
        drive_req(1'b0, SIZE_WORD, 1'b0, 32'h00000080, 32'd0);
        expect_rsp(1'b1, 32'd0, 5);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("tmo_read_held", 32'(read), 32'd1);
        end
        @(negedge clk);
        check("tmo_read_dropped", 32'(read), 32'd0);
        wait_rsp();
        stall_cfg = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
